// File: rtl/huffman_pkg.sv
// Shared types and constants for the fixed Huffman encoder/decoder pair.
package huffman_pkg;

  localparam int SYM_W   = 6;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  localparam logic [SYM_W-1:0] SYM_MIN = 6'd1;
  localparam logic [SYM_W-1:0] SYM_MAX = 6'd18;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef struct packed {
    logic [MAX_LEN-1:0] bits;
    logic [LEN_W-1:0]   len;
  } code_t;

endpackage

// File: rtl/huffman_code_rom.sv
// Fixed codeword table, codes left-aligned in MAX_LEN bits.
module huffman_code_rom
  import huffman_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output code_t            code,
  output logic             valid
);

  always_comb begin
    code  = '0;
    valid = 1'b1;
    case (sym)
      6'd1:  code = '{bits: 8'b0000_0000, len: 4'd2};
      6'd2:  code = '{bits: 8'b0100_0000, len: 4'd2};
      6'd3:  code = '{bits: 8'b1000_0000, len: 4'd2};
      6'd4:  code = '{bits: 8'b1100_0000, len: 4'd3};
      6'd5:  code = '{bits: 8'b1110_0000, len: 4'd6};
      6'd6:  code = '{bits: 8'b1110_0100, len: 4'd6};
      6'd7:  code = '{bits: 8'b1110_1000, len: 4'd6};
      6'd8:  code = '{bits: 8'b1110_1100, len: 4'd7};
      6'd9:  code = '{bits: 8'b1110_1110, len: 4'd7};
      6'd10: code = '{bits: 8'b1111_0000, len: 4'd7};
      6'd11: code = '{bits: 8'b1111_0010, len: 4'd7};
      6'd12: code = '{bits: 8'b1111_0100, len: 4'd7};
      6'd13: code = '{bits: 8'b1111_0110, len: 4'd7};
      6'd14: code = '{bits: 8'b1111_1000, len: 4'd7};
      6'd15: code = '{bits: 8'b1111_1010, len: 4'd7};
      6'd16: code = '{bits: 8'b1111_1100, len: 4'd7};
      6'd17: code = '{bits: 8'b1111_1110, len: 4'd8};
      6'd18: code = '{bits: 8'b1111_1111, len: 4'd8};
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/huffman_encoder.sv
// Serial Huffman encoder: one symbol in, codeword bits out MSB first,
// with valid/ready on both sides and zero-bubble back-to-back symbols.
module huffman_encoder
  import huffman_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_i,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             busy,
  output logic             err
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               bv_q, bv_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  code_t rom_code;
  logic  rom_valid;
  logic  xfer;
  logic  last;
  logic  acc;

  huffman_code_rom u_rom (
    .sym   (sym_i),
    .code  (rom_code),
    .valid (rom_valid)
  );

  assign xfer      = bv_q && bit_ready;
  assign last      = xfer && (cnt_q == LEN_W'(1));
  assign sym_ready = (state_q == IDLE) || last;
  assign acc       = sym_valid && sym_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bv_d    = bv_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    if (xfer) begin
      sr_d  = sr_q << 1;
      cnt_d = cnt_q - LEN_W'(1);
    end
    if (last) begin
      state_d = IDLE;
      bv_d    = 1'b0;
      busy_d  = 1'b0;
    end
    if (acc) begin
      if (rom_valid) begin
        state_d = SHIFT;
        sr_d    = rom_code.bits;
        cnt_d   = rom_code.len;
        bv_d    = 1'b1;
        busy_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bv_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bv_q    <= bv_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Shifting in zeros keeps the register clear once a code drains.
  assign bit_out   = bv_q & sr_q[MAX_LEN-1];
  assign bit_valid = bv_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
